// File: rtl/iteration_color_pipeline_pkg.sv
// Shared constants and palette encoding for the iteration-to-colour pipeline.
package iteration_color_pipeline_pkg;

  localparam int PIXEL_W = 24;
  localparam int ITER_W  = 8;

  typedef enum logic [1:0] {
    PAL_GREY    = 2'd0,
    PAL_RAMP    = 2'd1,
    PAL_INVERSE = 2'd2,
    PAL_BANDED  = 2'd3
  } palette_e;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and occupancy count.
module pixel_fifo #(
  parameter int depth = 16,
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     SYS_RESETn,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         pop_data,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] full_count = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count != full_count);
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo depth on their own.
  always_ff @(posedge clk) begin
    if (!SYS_RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iteration_color_pipeline.sv
// Buffers DDR iteration counts and maps each requested one to RGB through a
// two-stage pipeline using a palette that only changes at end of line.
module iteration_color_pipeline
  import iteration_color_pipeline_pkg::*;
#(
  parameter int max_iterations = 255,
  parameter int fifo_depth     = 16
) (
  input  logic                          clk,
  input  logic                          SYS_RESETn,
  input  logic [31:0]                   rd_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [3:0]                    SW,
  input  logic                          stream_data,
  input  logic                          end_line,
  output logic [PIXEL_W-1:0]            data_out,
  output logic                          data_out_valid,
  output logic                          underflow,
  output logic [$clog2(fifo_depth):0]   fill_count
);

  localparam int CW = $clog2(fifo_depth) + 1;
  localparam logic [CW-1:0]     full_count = CW'(fifo_depth);
  localparam logic [ITER_W:0]   max_iter   = (ITER_W+1)'(max_iterations);

  logic              ready_en;
  logic              push;
  logic              pop;
  logic [ITER_W-1:0] fifo_data;
  palette_e          active_pal;
  logic              s1_valid;
  logic [ITER_W-1:0] s1_iter;
  palette_e          s1_pal;
  logic              unused_bits;

  assign unused_bits = ^{rd_data[31:ITER_W], SW[3:2]};

  // Handshake: a word moves when rd_valid && rd_ready at a rising edge; rd_ready
  // depends only on registered state (count and a post-reset enable), never on
  // rd_valid, and the producer must hold rd_data steady until it is taken.
  assign rd_ready = ready_en && (fill_count != full_count);
  assign push     = rd_valid && rd_ready;
  assign pop      = stream_data && (fill_count != '0);

  pixel_fifo #(
    .depth (fifo_depth),
    .width (ITER_W)
  ) u_fifo (
    .clk        (clk),
    .SYS_RESETn (SYS_RESETn),
    .push       (push),
    .push_data  (rd_data[ITER_W-1:0]),
    .pop        (pop),
    .pop_data   (fifo_data),
    .count      (fill_count)
  );

  function automatic logic [PIXEL_W-1:0] color_map(input logic [ITER_W-1:0] i,
                                                   input palette_e pal);
    logic [PIXEL_W-1:0] rgb;
    rgb = '0;
    if ({1'b0, i} < max_iter) begin
      case (pal)
        PAL_GREY:    rgb = {i, i, i};
        PAL_RAMP:    rgb = {i, i[6:0], 1'b0, i[5:0], 2'b00};
        PAL_INVERSE: rgb = {~i, ~i, 8'hFF};
        PAL_BANDED:  rgb = {i[2:0], 5'b0, i[5:3], 5'b0, i[7:6], 6'b0};
        default:     rgb = '0;
      endcase
    end
    return rgb;
  endfunction

  // Stage 1 captures the palette in force before any same-cycle end_line update.
  always_ff @(posedge clk) begin
    if (!SYS_RESETn) begin
      ready_en       <= 1'b0;
      active_pal     <= PAL_GREY;
      s1_valid       <= 1'b0;
      s1_iter        <= '0;
      s1_pal         <= PAL_GREY;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (end_line) active_pal <= palette_e'(SW[1:0]);
      s1_valid <= pop;
      if (pop) begin
        s1_iter <= fifo_data;
        s1_pal  <= active_pal;
      end
      if (stream_data && (fill_count == '0)) underflow <= 1'b1;
      data_out_valid <= s1_valid;
      if (s1_valid) data_out <= color_map(s1_iter, s1_pal);
    end
  end

endmodule
